// File: rtl/spec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spec_pkg
//  Description : Shared defaults, controller state encoding and the modular
//                offset helper for the speculation-tag controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package spec_pkg;

    localparam int SPEC_ID_W     = 5;
    localparam int SPEC_NUM_TAGS = 16;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } spec_state_e;

    // Distance of id from head in the circular ID space; this is the youth
    // order used for every outstanding/younger comparison.
    function automatic logic [31:0] spec_off(
        input logic [31:0] id,
        input logic [31:0] head,
        input int unsigned id_w
    );
        logic [31:0] diff;
        logic [31:0] mask;
        diff = id - head;
        mask = (32'd1 << id_w) - 32'd1;
        return diff & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spec_done_ring.sv
`default_nettype none
// ============================================================================
//  Module      : spec_done_ring
//  Description : Ring of per-tag done bits indexed by id mod NUM_TAGS, with a
//                set port, a clear port and two read ports (head and check).
//  Revision    : 1.0 - initial release
// ============================================================================
module spec_done_ring #(
    parameter int NUM_TAGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] head_idx,
    output logic             head_done,
    input  logic [IDX_W-1:0] chk_idx,
    output logic             chk_done
);

    logic [NUM_TAGS-1:0] r_done;

    // Clear a slot when its ID is (re)allocated, set it when the branch resolves.
    // The allocating slot is never outstanding, so set and clear never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= '0;
        end else begin
            if (clr_en) r_done[clr_idx] <= 1'b0;
            if (set_en) r_done[set_idx] <= 1'b1;
        end
    end

    assign head_done = r_done[head_idx];
    assign chk_done  = r_done[chk_idx];

endmodule
`default_nettype wire

// File: rtl/spec_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spec_tag_ctrl
//  Description : In-order speculation-ID allocator/retirer. Sequences the
//                (invalid, missId) squash broadcast on a mispredict.
//                Optional macro SPEC_TAG_ERR_CHK_EN adds a sticky err output
//                flagging out-of-window or duplicate resolves.
//  Revision    : 1.0 - initial release
// ============================================================================
module spec_tag_ctrl
    import spec_pkg::*;
#(
    parameter int ID_W         = SPEC_ID_W,
    parameter int NUM_TAGS     = SPEC_NUM_TAGS,
    parameter int SCRUB_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_req,
    output logic            alloc_gnt,
    output logic [ID_W-1:0] alloc_id,
    input  logic            resolve_valid,
    input  logic [ID_W-1:0] resolve_id,
    input  logic            resolve_miss,
    output logic            invalid,
    output logic [ID_W-1:0] missId,
    output logic [ID_W-1:0] oldest_id,
    output logic [ID_W-1:0] count,
    output logic            busy
`ifdef SPEC_TAG_ERR_CHK_EN
    ,
    output logic            err
`endif
);

    localparam int              c_IDX_W     = $clog2(NUM_TAGS);
    localparam int              c_SCR_W     = (SCRUB_CYCLES > 1) ? $clog2(SCRUB_CYCLES) : 1;
    localparam logic [ID_W-1:0] c_NUM_TAGS  = ID_W'(NUM_TAGS);
    localparam logic [0:0]      c_ST_RUN    = RUN;
    localparam logic [0:0]      c_ST_SQUASH = SQUASH;

    logic [0:0]         r_state;
    logic [ID_W-1:0]    r_head;
    logic [ID_W-1:0]    r_tail;
    logic [ID_W-1:0]    r_count;
    logic [ID_W-1:0]    r_miss_id;
    logic [c_SCR_W-1:0] r_scrub;

    logic [ID_W-1:0]    w_res_off;
    logic               w_res_out;
    logic               w_miss;
    logic               w_corr;
    logic               w_set;
    logic               w_gnt;
    logic               w_ret;
    logic               w_head_done;
    logic               w_chk_done;
    logic [ID_W-1:0]    w_count_nxt;

    assign w_res_off = ID_W'(spec_off(32'(resolve_id), 32'(r_head), ID_W));
    assign w_res_out = (w_res_off < r_count);

    // Only RUN accepts a mispredict; in SQUASH the window is already cut back.
    assign w_miss = (r_state == c_ST_RUN) & resolve_valid & resolve_miss & w_res_out;
    assign w_corr = resolve_valid & ~resolve_miss & w_res_out;
    assign w_set  = w_miss | (w_corr & ~w_chk_done);

    assign w_gnt  = (r_state == c_ST_RUN) & alloc_req & (r_count < c_NUM_TAGS) & ~w_miss;
    assign w_ret  = w_head_done & (r_count != '0);

    spec_done_ring #(
        .NUM_TAGS (NUM_TAGS),
        .IDX_W    (c_IDX_W)
    ) u_done_ring (
        .clk       (clk),
        .rst       (rst),
        .set_en    (w_set),
        .set_idx   (resolve_id[c_IDX_W-1:0]),
        .clr_en    (w_gnt),
        .clr_idx   (r_tail[c_IDX_W-1:0]),
        .head_idx  (r_head[c_IDX_W-1:0]),
        .head_done (w_head_done),
        .chk_idx   (resolve_id[c_IDX_W-1:0]),
        .chk_done  (w_chk_done)
    );

    // Outstanding count: a mispredict truncates the window just past the missed ID.
    always_comb begin
        w_count_nxt = r_count;
        if (w_miss) begin
            w_count_nxt = w_res_off + ID_W'(1);
        end else if (w_gnt) begin
            w_count_nxt = r_count + ID_W'(1);
        end
        if (w_ret) begin
            w_count_nxt = w_count_nxt - ID_W'(1);
        end
    end

    // Pointers, FSM and the squash broadcast registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_RUN;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_miss_id <= '0;
            r_scrub   <= '0;
        end else begin
            if (w_miss) begin
                r_tail    <= resolve_id + ID_W'(1);
                r_miss_id <= resolve_id + ID_W'(1);
                r_state   <= c_ST_SQUASH;
                r_scrub   <= c_SCR_W'(SCRUB_CYCLES - 1);
            end else if (w_gnt) begin
                r_tail <= r_tail + ID_W'(1);
            end
            if (r_state == c_ST_SQUASH) begin
                if (r_scrub == '0) begin
                    r_state <= c_ST_RUN;
                end else begin
                    r_scrub <= r_scrub - c_SCR_W'(1);
                end
            end
            r_head  <= r_head + ID_W'(w_ret);
            r_count <= w_count_nxt;
        end
    end

`ifdef SPEC_TAG_ERR_CHK_EN
    // Sticky flag for a resolve outside the window or of an already-done ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (resolve_valid & (~w_res_out | w_chk_done)) begin
            err <= 1'b1;
        end
    end
`endif

    assign alloc_gnt = w_gnt;
    assign alloc_id  = r_tail;
    assign invalid   = (r_state == c_ST_SQUASH);
    assign busy      = (r_state == c_ST_SQUASH);
    assign missId    = r_miss_id;
    assign oldest_id = r_head;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_spec_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spec_tag_ctrl
//  Description : Self-checking bench for spec_tag_ctrl using a queue-based
//                reference model of the outstanding-ID window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spec_tag_ctrl;

    localparam int ID_W     = 5;
    localparam int NUM_TAGS = 16;
    localparam int SCRUB    = 2;
    localparam int MOD      = 32;

    logic            clk;
    logic            rst;
    logic            alloc_req;
    logic            alloc_gnt;
    logic [ID_W-1:0] alloc_id;
    logic            resolve_valid;
    logic [ID_W-1:0] resolve_id;
    logic            resolve_miss;
    logic            invalid;
    logic [ID_W-1:0] missId;
    logic [ID_W-1:0] oldest_id;
    logic [ID_W-1:0] count;
    logic            busy;
`ifdef SPEC_TAG_ERR_CHK_EN
    logic            err;
`endif

    spec_tag_ctrl #(
        .ID_W         (ID_W),
        .NUM_TAGS     (NUM_TAGS),
        .SCRUB_CYCLES (SCRUB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_req     (alloc_req),
        .alloc_gnt     (alloc_gnt),
        .alloc_id      (alloc_id),
        .resolve_valid (resolve_valid),
        .resolve_id    (resolve_id),
        .resolve_miss  (resolve_miss),
        .invalid       (invalid),
        .missId        (missId),
        .oldest_id     (oldest_id),
        .count         (count),
        .busy          (busy)
`ifdef SPEC_TAG_ERR_CHK_EN
        ,
        .err           (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the outstanding window as an ordered list, oldest first.
    typedef struct {
        logic [ID_W-1:0] id;
        bit              done;
    } ent_t;

    ent_t q[$];
    int   m_head;
    int   m_tail;
    int   m_miss_id;
    bit   m_sq;
    int   m_sq_left;
    bit   m_err;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_head    = 0;
        m_tail    = 0;
        m_miss_id = 0;
        m_sq      = 1'b0;
        m_sq_left = 0;
        m_err     = 1'b0;
    endtask

    // One clock: drive, compare every output against the model, advance model.
    task automatic step(input bit a, input bit rv, input int rid, input bit rm, input bit r,
                        output bit g, output logic [ID_W-1:0] gid);
        int idx;
        bit outst, miss, gnt, ret, sq_was;
        @(negedge clk);
        rst           = r;
        alloc_req     = a;
        resolve_valid = rv;
        resolve_id    = ID_W'(rid);
        resolve_miss  = rm;
        #1;
        idx = -1;
        for (int i = 0; i < q.size(); i++) if (q[i].id == ID_W'(rid)) idx = i;
        outst = (idx >= 0);
        miss  = !m_sq && rv && rm && outst;
        gnt   = !m_sq && a && (q.size() < NUM_TAGS) && !miss;
        chk("alloc_gnt", 32'(alloc_gnt), 32'(gnt));
        chk("alloc_id",  32'(alloc_id),  32'(m_tail));
        chk("invalid",   32'(invalid),   32'(m_sq));
        chk("busy",      32'(busy),      32'(m_sq));
        chk("missId",    32'(missId),    32'(m_miss_id));
        chk("oldest_id", 32'(oldest_id), 32'(m_head));
        chk("count",     32'(count),     32'(q.size()));
`ifdef SPEC_TAG_ERR_CHK_EN
        chk("err",       32'(err),       32'(m_err));
`endif
        g   = alloc_gnt;
        gid = alloc_id;
        if (r) begin
            model_reset();
        end else begin
            ret    = (q.size() > 0) && q[0].done;
            sq_was = m_sq;
            if (rv && (!outst || q[idx].done)) m_err = 1'b1;
            if (miss) begin
                while (q.size() > idx + 1) void'(q.pop_back());
                q[idx].done = 1'b1;
                m_tail      = (rid + 1) % MOD;
                m_miss_id   = m_tail;
                m_sq        = 1'b1;
                m_sq_left   = SCRUB - 1;
            end else begin
                if (rv && !rm && outst) q[idx].done = 1'b1;
                if (gnt) begin
                    q.push_back('{ID_W'(m_tail), 1'b0});
                    m_tail = (m_tail + 1) % MOD;
                end
            end
            if (ret) begin
                void'(q.pop_front());
                m_head = (m_head + 1) % MOD;
            end
            if (sq_was) begin
                if (m_sq_left == 0) m_sq = 1'b0;
                else m_sq_left--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bit g;
        logic [ID_W-1:0] gid;
        step(0, 0, 0, 0, 1, g, gid);
        step(0, 0, 0, 0, 1, g, gid);
    endtask

    initial begin
        bit g;
        logic [ID_W-1:0] gid;
        bit a, rv, rm, r;
        int rid;

        rst = 1'b1; alloc_req = 1'b0; resolve_valid = 1'b0;
        resolve_id = '0; resolve_miss = 1'b0;
        model_reset();

        // Reset state and fill to capacity
        do_reset();
        chk("rst_count", 32'(count), 0);
        chk("rst_invalid", 32'(invalid), 0);
        chk("rst_alloc_id", 32'(alloc_id), 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 0, g, gid);
            chk("fill_gnt", 32'(g), 1);
            chk("fill_id", 32'(gid), 32'(i));
        end
        step(1, 0, 0, 0, 0, g, gid);
        chk("full_refuse", 32'(g), 0);
        chk("full_count", 32'(count), 16);

        // Out-of-order resolves, in-order retirement
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, g, gid);
        step(0, 1, 2, 0, 0, g, gid);
        step(0, 1, 0, 0, 0, g, gid);
        step(0, 1, 1, 0, 0, g, gid);
        chk("retire_h1", 32'(oldest_id), 1);
        step(0, 0, 0, 0, 0, g, gid);
        chk("retire_h2", 32'(oldest_id), 2);
        step(0, 0, 0, 0, 0, g, gid);
        chk("retire_h3", 32'(oldest_id), 3);
        chk("retire_count", 32'(count), 1);

        // Mispredict and squash hold
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, g, gid);
        step(1, 1, 2, 1, 0, g, gid);
        chk("miss_nogrant", 32'(g), 0);
        chk("miss_invalid", 32'(invalid), 1);
        chk("miss_missId", 32'(missId), 3);
        chk("miss_tail", 32'(alloc_id), 3);
        chk("miss_count", 32'(count), 3);
        step(1, 1, 4, 1, 0, g, gid);
        chk("sq_nogrant", 32'(g), 0);
        chk("sq_hold", 32'(invalid), 1);
        chk("sq_ignore_cnt", 32'(count), 3);
        step(0, 1, 0, 0, 0, g, gid);
        chk("sq_end", 32'(invalid), 0);
        chk("sq_missId_hold", 32'(missId), 3);
        step(1, 1, 1, 0, 0, g, gid);
        chk("post_gnt", 32'(g), 1);
        chk("post_id", 32'(gid), 3);
        step(0, 0, 0, 0, 0, g, gid);
        chk("post_head2", 32'(oldest_id), 2);
        step(0, 0, 0, 0, 0, g, gid);
        chk("post_head3", 32'(oldest_id), 3);
        chk("post_count", 32'(count), 1);

        // Wrap with immediate resolves
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1, i > 0, (i - 1) % MOD, 0, 0, g, gid);
            chk("wrap_gnt", 32'(g), 1);
            chk("wrap_id", 32'(gid), 32'(i % MOD));
        end

        // Out-of-window resolve
        do_reset();
        step(1, 0, 0, 0, 0, g, gid);
        step(1, 0, 0, 0, 0, g, gid);
        step(0, 1, 20, 0, 0, g, gid);
        chk("oow_count", 32'(count), 2);
`ifdef SPEC_TAG_ERR_CHK_EN
        chk("oow_err", 32'(err), 1);
`endif

        // Reset during squash
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, g, gid);
        step(0, 1, 1, 1, 0, g, gid);
        step(0, 0, 0, 0, 0, g, gid);
        step(0, 0, 0, 0, 1, g, gid);
        chk("rstsq_invalid", 32'(invalid), 0);
        chk("rstsq_busy", 32'(busy), 0);
        chk("rstsq_count", 32'(count), 0);
        chk("rstsq_alloc_id", 32'(alloc_id), 0);

        // Randomized traffic: resolve-light phase then resolve-heavy phase
        for (int n = 0; n < 3000; n++) begin
            a   = ($urandom_range(0, 9) < 7);
            rv  = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rid = (m_head + int'($urandom_range(0, 19))) % MOD;
            rm  = ($urandom_range(0, 15) == 0);
            r   = ($urandom_range(0, 399) == 0);
            step(a, rv, rid, rm, r, g, gid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
